// File: rtl/pcie_bar_csr_responder.sv
// BAR0 CSR responder for the PCIe HIP Avalon-MM master: ID, scratch, control, EMIF status, uptime, LED, doorbell IRQ.
// Optional interrupt path (DOORBELL/IRQ_STATUS, irq output) is built only when CSR_IRQ_EN is defined.
module pcie_bar_csr_responder #(
  parameter int          ADDR_W      = 6,
  parameter int          RD_LATENCY  = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA10D_3008,
  parameter int          HB_BIT      = 23,
  parameter logic [63:0] UPTIME_INIT = 64'd0
) (
  input  logic              core_clkout,
  input  logic              perstn_perstn,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              emif_cal_success,
  input  logic              emif_cal_fail,
  output logic              led_alive,
  output logic              irq
);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge core_clkout or negedge perstn_perstn)
    if (!perstn_perstn) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n = rst_sync[1];

  // Hold off the host for two cycles after the synchronised release.
  logic [1:0] wait_pipe;
  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) wait_pipe <= 2'b00;
    else        wait_pipe <= {wait_pipe[0], 1'b1};

  assign avs_waitrequest = ~wait_pipe[1];

  logic wr_acc, rd_acc;
  assign wr_acc = avs_write & ~avs_waitrequest;
  assign rd_acc = avs_read & ~avs_write & ~avs_waitrequest;

  logic [1:0] ok_sync, fail_sync;
  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) begin
      ok_sync   <= 2'b00;
      fail_sync <= 2'b00;
    end else begin
      ok_sync   <= {ok_sync[0], emif_cal_success};
      fail_sync <= {fail_sync[0], emif_cal_fail};
    end

  logic [63:0] uptime;
  logic [31:0] uptime_hi_shadow;
  logic        led_q;
  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) begin
      uptime           <= UPTIME_INIT;
      uptime_hi_shadow <= 32'd0;
      led_q            <= 1'b0;
    end else begin
      uptime <= uptime + 64'd1;
      led_q  <= uptime[HB_BIT];
      // HI is latched from the same counter value that LO returns.
      if (rd_acc && avs_address == ADDR_W'(4)) uptime_hi_shadow <= uptime[63:32];
    end

  assign led_alive = led_q;

  logic [31:0] scratch;
  logic        irq_en;
  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) begin
      scratch <= 32'd0;
      irq_en  <= 1'b0;
    end else if (wr_acc) begin
      if (avs_address == ADDR_W'(1))
        for (int b = 0; b < 4; b++)
          if (avs_byteenable[b]) scratch[8*b +: 8] <= avs_writedata[8*b +: 8];
      if (avs_address == ADDR_W'(2) && avs_byteenable[0]) irq_en <= avs_writedata[0];
    end

`ifdef CSR_IRQ_EN
  logic [1:0] irq_sts, sts_set, sts_clr;
  logic       fail_d, irq_q;

  always_comb begin
    sts_set    = 2'b00;
    sts_clr    = 2'b00;
    sts_set[0] = wr_acc && avs_address == ADDR_W'(6) && avs_byteenable[0] && avs_writedata[0];
    sts_set[1] = fail_sync[1] & ~fail_d;
    if (wr_acc && avs_address == ADDR_W'(7) && avs_byteenable[0]) sts_clr = avs_writedata[1:0];
  end

  // Set wins over a same-cycle W1C so no event is lost.
  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) begin
      irq_sts <= 2'b00;
      fail_d  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_sts <= (irq_sts & ~sts_clr) | sts_set;
      fail_d  <= fail_sync[1];
      irq_q   <= irq_en & |irq_sts;
    end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    case (int'(avs_address))
      0: rd_data = ID_VALUE;
      1: rd_data = scratch;
      2: rd_data = {31'd0, irq_en};
      3: rd_data = {30'd0, fail_sync[1], ok_sync[1]};
      4: rd_data = uptime[31:0];
      5: rd_data = uptime_hi_shadow;
      6: rd_data = 32'd0;
`ifdef CSR_IRQ_EN
      7: rd_data = {30'd0, irq_sts};
`else
      7: rd_data = 32'd0;
`endif
      default: ;
    endcase
  end

  // Stage 0 is the accept cycle; data is frozen there and walks with its valid bit.
  logic [RD_LATENCY:0]       vld_pipe;
  logic [RD_LATENCY:1]       vld_q;
  logic [RD_LATENCY:0][31:0] dat_pipe;
  logic [RD_LATENCY:1][31:0] dat_q;

  assign vld_pipe = {vld_q, rd_acc};
  assign dat_pipe = {dat_q, rd_data};

  always_ff @(posedge core_clkout or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LATENCY-1:0];
      dat_q <= dat_pipe[RD_LATENCY-1:0];
    end

  assign avs_readdatavalid = vld_pipe[RD_LATENCY];
  assign avs_readdata      = dat_pipe[RD_LATENCY];

endmodule

// File: tb/tb_pcie_bar_csr_responder.sv
// Bench for pcie_bar_csr_responder: vector table, hand sequences and random traffic against a transaction model.
module tb_pcie_bar_csr_responder;
  localparam int          L      = 2;
  localparam int          LB     = 4;
  localparam logic [63:0] INIT_B = 64'h0000_0000_FFFF_FFF1;

  logic core_clkout = 1'b0;
  always #5 core_clkout = ~core_clkout;

  logic        perstn_perstn, avs_read, avs_write, avs_waitrequest, avs_readdatavalid;
  logic [5:0]  avs_address;
  logic [31:0] avs_writedata, avs_readdata;
  logic [3:0]  avs_byteenable;
  logic        emif_cal_success, emif_cal_fail, led_alive, irq;

  logic        b_perstn, b_read, b_write, b_waitrequest, b_readdatavalid, b_led, b_irq;
  logic [5:0]  b_address;
  logic [31:0] b_writedata, b_readdata;
  logic [3:0]  b_byteenable;

  pcie_bar_csr_responder #(.RD_LATENCY(L)) dut (
    .core_clkout(core_clkout), .perstn_perstn(perstn_perstn),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .emif_cal_success(emif_cal_success),
    .emif_cal_fail(emif_cal_fail), .led_alive(led_alive), .irq(irq));

  pcie_bar_csr_responder #(.RD_LATENCY(LB), .UPTIME_INIT(INIT_B)) dut_b (
    .core_clkout(core_clkout), .perstn_perstn(b_perstn),
    .avs_address(b_address), .avs_read(b_read), .avs_write(b_write),
    .avs_writedata(b_writedata), .avs_byteenable(b_byteenable),
    .avs_waitrequest(b_waitrequest), .avs_readdata(b_readdata),
    .avs_readdatavalid(b_readdatavalid), .emif_cal_success(1'b0),
    .emif_cal_fail(1'b0), .led_alive(b_led), .irq(b_irq));

  int n_vec = 0, n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model of the register file
  typedef struct { int due; logic [31:0] d; } rsp_t;
  rsp_t        q[$];
  int          rel = 0, cyc = 0;
  logic [31:0] m_scr = 0, m_shadow = 0, last_rd = 0;
  logic        m_ctl = 0, m_irq = 0;
  logic [1:0]  m_ists = 0;
  logic        m_ok1 = 0, m_ok2 = 0, m_f1 = 0, m_f2 = 0, m_fprev = 0;
  logic [7:0]  rdv_hist = 0;

  function automatic logic [63:0] m_up();
    return (rel >= 2) ? 64'(rel - 2) : 64'd0;
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] a, logic [63:0] up);
    case (a)
      6'd0: return 32'hA10D_3008;
      6'd1: return m_scr;
      6'd2: return {31'd0, m_ctl};
      6'd3: return {30'd0, m_f2, m_ok2};
      6'd4: return up[31:0];
      6'd5: return m_shadow;
      6'd6: return 32'd0;
`ifdef CSR_IRQ_EN
      6'd7: return {30'd0, m_ists};
`else
      6'd7: return 32'd0;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic step();
    logic        acc_rd, acc_wr, irq_n, exp_v;
    logic [1:0]  set, clr;
    logic [63:0] up_now;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    a = avs_address; wd = avs_writedata; be = avs_byteenable;
    up_now = m_up();
    acc_wr = avs_write && rel >= 4;
    acc_rd = avs_read && !avs_write && rel >= 4;
    if (acc_rd) q.push_back('{cyc + L, m_read(a, up_now)});
    set = 2'b00; clr = 2'b00; irq_n = 1'b0;
`ifdef CSR_IRQ_EN
    irq_n  = m_ctl & |m_ists;
    set[0] = acc_wr && a == 6'd6 && be[0] && wd[0];
    set[1] = m_f2 & ~m_fprev;
    if (acc_wr && a == 6'd7 && be[0]) clr = wd[1:0];
`endif
    @(posedge core_clkout);
    cyc++;
    if (!perstn_perstn) begin
      rel = 0; m_scr = 0; m_shadow = 0; m_ctl = 0; m_irq = 0; m_ists = 0;
      m_ok1 = 0; m_ok2 = 0; m_f1 = 0; m_f2 = 0; m_fprev = 0;
      q.delete();
    end else begin
      if (rel >= 2) begin
        if (acc_wr && a == 6'd1)
          for (int b = 0; b < 4; b++) if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
        if (acc_wr && a == 6'd2 && be[0]) m_ctl = wd[0];
        if (acc_rd && a == 6'd4) m_shadow = up_now[63:32];
        m_ists = (m_ists & ~clr) | set;
        m_irq = irq_n;
        m_fprev = m_f2; m_f2 = m_f1; m_f1 = emif_cal_fail;
        m_ok2 = m_ok1; m_ok1 = emif_cal_success;
      end
      if (rel < 100000) rel++;
    end
    @(negedge core_clkout);
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    rdv_hist = {rdv_hist[6:0], avs_readdatavalid};
    chk("readdatavalid", avs_readdatavalid, exp_v);
    if (exp_v) begin
      chk("readdata", avs_readdata, q[0].d);
      last_rd = avs_readdata;
      void'(q.pop_front());
    end
    chk("waitrequest", avs_waitrequest, rel < 4);
    chk("irq", irq, m_irq);
    chk("led_alive", led_alive, m_up() >= 64'd1 ? 64'(((m_up() - 64'd1) >> 23) & 64'd1) : 64'd0);
  endtask

  task automatic idle(int n);
    avs_read = 0; avs_write = 0;
    repeat (n) step();
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d, logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1; avs_read = 0;
    step();
    avs_write = 0;
  endtask

  task automatic rd_wait(logic [5:0] a, output logic [31:0] d);
    last_rd = 32'h0BAD_0BAD;
    avs_address = a; avs_read = 1; avs_write = 0;
    step();
    avs_read = 0;
    repeat (L) step();
    d = last_rd;
  endtask

  typedef struct {
    logic do_wr; logic [5:0] wa; logic [31:0] wd; logic [3:0] be;
    logic [5:0] ra; logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, a0, a1, lo, hi;
    logic [63:0] v;
    logic [31:0] resp[$];
    int k, nrdv;

    tbl[0]  = '{1'b0, 6'd0,  32'h0,        4'h0, 6'd0,  32'hA10D_3008};
    tbl[1]  = '{1'b1, 6'd1,  32'h1234_5678, 4'hF, 6'd1,  32'h1234_5678};
    tbl[2]  = '{1'b1, 6'd1,  32'h0000_AB00, 4'h2, 6'd1,  32'h1234_AB78};
    tbl[3]  = '{1'b1, 6'd2,  32'hFFFF_FFFF, 4'hF, 6'd2,  32'h0000_0001};
    tbl[4]  = '{1'b1, 6'd0,  32'hFFFF_FFFF, 4'hF, 6'd0,  32'hA10D_3008};
    tbl[5]  = '{1'b0, 6'd0,  32'h0,        4'h0, 6'd9,  32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 6'd9,  32'h0000_0001, 4'hF, 6'd63, 32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 6'd3,  32'hFFFF_FFFF, 4'hF, 6'd3,  32'h0000_0001};
    tbl[8]  = '{1'b1, 6'd2,  32'h0000_0000, 4'h0, 6'd2,  32'h0000_0001};
    tbl[9]  = '{1'b1, 6'd1,  32'hFFFF_FFFF, 4'h8, 6'd1,  32'hFF34_AB78};
    tbl[10] = '{1'b0, 6'd0,  32'h0,        4'h0, 6'd6,  32'h0000_0000};
    tbl[11] = '{1'b1, 6'd2,  32'h0000_0000, 4'h1, 6'd2,  32'h0000_0000};
    tbl[12] = '{1'b0, 6'd0,  32'h0,        4'h0, 6'd5,  32'h0000_0000};
    tbl[13] = '{1'b1, 6'd7,  32'h0000_0003, 4'hF, 6'd7,  32'h0000_0000};

    perstn_perstn = 0; avs_read = 0; avs_write = 0; avs_address = 0;
    avs_writedata = 0; avs_byteenable = 0; emif_cal_success = 1; emif_cal_fail = 0;
    b_perstn = 0; b_read = 0; b_write = 0; b_address = 0; b_writedata = 0; b_byteenable = 0;
    @(negedge core_clkout);

    idle(3);
    chk("rst_waitrequest", avs_waitrequest, 1);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_readdatavalid", avs_readdatavalid, 0);
    chk("rst_led", led_alive, 0);
    chk("rst_irq", irq, 0);

    perstn_perstn = 1;
    k = 0;
    do begin step(); k++; end while (avs_waitrequest && k < 10);
    chk("wait_release_cycles", k, 4);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd, tbl[i].be);
      rd_wait(tbl[i].ra, d);
      chk($sformatf("vec%0d", i), d, tbl[i].exp);
    end

    // Four back-to-back reads must produce four consecutive valids
    avs_read = 1;
    foreach (tbl[i]) if (i < 4) begin
      avs_address = (i == 0) ? 6'd0 : (i == 1) ? 6'd1 : (i == 2) ? 6'd3 : 6'd9;
      step();
    end
    idle(L + 2);
    chk("b2b_valid_pattern", rdv_hist, 8'b0111_1000);
    chk("b2b_last_data", last_rd, 32'hDEAD_BEEF);

    avs_address = 1; avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
    avs_read = 1; avs_write = 1;
    step();
    idle(L + 2);
    chk("rdwr_no_valid", rdv_hist[L+2:0], 0);
    rd_wait(1, d);
    chk("rdwr_write_done", d, 32'hCAFE_F00D);

    rd_wait(4, a0);
    idle(5);
    rd_wait(4, a1);
    chk("uptime_delta", a1 - a0, 8);

    wr(2, 1, 4'hF);
    wr(6, 1, 4'hF);
    idle(1);
`ifdef CSR_IRQ_EN
    chk("doorbell_irq", irq, 1);
`else
    chk("doorbell_irq", irq, 0);
`endif
    wr(7, 1, 4'hF);
    idle(1);
    chk("w1c_irq_clear", irq, 0);
    emif_cal_fail = 1;
    idle(5);
    rd_wait(7, d);
`ifdef CSR_IRQ_EN
    chk("cal_fail_evt", d, 2);
    chk("cal_fail_irq", irq, 1);
`else
    chk("cal_fail_evt", d, 0);
    chk("cal_fail_irq", irq, 0);
`endif
    rd_wait(3, d);
    chk("status_both", d, 3);
    wr(7, 2, 4'hF);
    emif_cal_fail = 0;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      avs_read = 1'($urandom_range(0, 1));
      avs_write = ($urandom_range(0, 3) == 0);
      avs_address = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
      avs_writedata = $urandom;
      avs_byteenable = 4'($urandom);
      if ($urandom_range(0, 49) == 0) emif_cal_fail = ~emif_cal_fail;
      if ($urandom_range(0, 49) == 0) emif_cal_success = ~emif_cal_success;
      step();
    end
    idle(L + 2);
    chk("queue_drained", q.size(), 0);

    // Second instance: uptime carry coherence at LO wrap, then reset mid-read
    b_perstn = 1;
    k = 0;
    do begin @(posedge core_clkout); @(negedge core_clkout); k++; end while (b_waitrequest && k < 10);
    chk("b_wait_release_cycles", k, 4);
    chk("b_led", b_led, 1);
    for (int i = 0; i < 30; i++) begin
      b_read = (i < 24);
      b_address = (i % 2) ? 6'd5 : 6'd4;
      @(posedge core_clkout); @(negedge core_clkout);
      if (b_readdatavalid) resp.push_back(b_readdata);
    end
    b_read = 0;
    chk("b_resp_count", resp.size(), 24);
    if (resp.size() == 24)
      for (int p = 0; p < 12; p++) begin
        v = INIT_B + 64'd2 + 64'(2 * p);
        lo = resp[2*p]; hi = resp[2*p+1];
        chk($sformatf("uptime_lo%0d", p), lo, v[31:0]);
        chk($sformatf("uptime_hi%0d", p), hi, v[63:32]);
      end

    b_read = 1; b_address = 0;
    @(posedge core_clkout); @(negedge core_clkout);
    @(posedge core_clkout); @(negedge core_clkout);
    b_read = 0;
    @(posedge core_clkout); @(negedge core_clkout);
    b_perstn = 0;
    #1;
    chk("b_rst_waitrequest", b_waitrequest, 1);
    chk("b_rst_readdata", b_readdata, 0);
    chk("b_rst_readdatavalid", b_readdatavalid, 0);
    chk("b_rst_led", b_led, 0);
    chk("b_rst_irq", b_irq, 0);
    repeat (2) @(negedge core_clkout);
    b_perstn = 1;
    nrdv = 0;
    repeat (12) begin
      @(posedge core_clkout); @(negedge core_clkout);
      if (b_readdatavalid) nrdv++;
    end
    chk("b_no_stale_valid", nrdv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
